// File: rtl/pubkey_uart_pkg.sv
// Shared constants, state encodings and hex helper for the public-key UART streamer.
// Define UART_CRLF_EN to terminate each message with CR LF instead of LF alone.
package pubkey_uart_pkg;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] NIBBLES  = 8'd128;
`ifdef UART_CRLF_EN
   localparam logic [7:0] MSG_LEN  = 8'd130;
`else
   localparam logic [7:0] MSG_LEN  = 8'd129;
`endif

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
   typedef enum logic [1:0] {MSG_IDLE, MSG_SEND, MSG_DONE} msg_state_e;

   // 0-9 map to '0'-'9', 10-15 map to lowercase 'a'-'f'
   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
      if (nib < 4'd10) return 8'h30 + {4'h0, nib};
      else             return 8'h57 + {4'h0, nib};
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser; ready is also high in the last stop-bit cycle so the
// next byte can follow with no idle gap.
module uart_tx_byte
   import pubkey_uart_pkg::*;
#(
   parameter int BAUD_DIV = 104
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] byte_in,
   output logic       ready,
   output logic       txd
);

   localparam int               CNT_W     = $clog2(BAUD_DIV);
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

   tx_state_e        state, state_nxt;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;
   logic             baud_end, load, txd_nxt;

   assign baud_end = (baud_cnt == BAUD_LAST);
   assign ready    = (state == TX_IDLE) || ((state == TX_STOP) && baud_end);
   assign load     = ready && start;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= TX_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         txd      <= 1'b1;
      end else begin
         state    <= state_nxt;
         txd      <= txd_nxt;
         baud_cnt <= ((state == TX_IDLE) || baud_end) ? '0 : baud_cnt + 1'b1;
         if ((state == TX_DATA) && baud_end) bit_idx <= bit_idx + 3'd1;
      end
   end

   // shift register is pure data: loaded on accept, shifted at each data-bit end
   always_ff @(posedge clk) begin
      if (load)                                shreg <= byte_in;
      else if ((state == TX_DATA) && baud_end) shreg <= {1'b0, shreg[7:1]};
   end

   always_comb begin
      state_nxt = state;
      case (state)
         TX_IDLE:  if (start)                          state_nxt = TX_START;
         TX_START: if (baud_end)                       state_nxt = TX_DATA;
         TX_DATA:  if (baud_end && (bit_idx == 3'd7))  state_nxt = TX_STOP;
         TX_STOP:  if (baud_end)                       state_nxt = start ? TX_START : TX_IDLE;
         default:                                      state_nxt = TX_IDLE;
      endcase
   end

   // txd is computed from the next state so the pin is a clean flop output
   always_comb begin
      case (state_nxt)
         TX_START: txd_nxt = 1'b0;
         TX_DATA:  txd_nxt = ((state == TX_DATA) && baud_end) ? shreg[1] : shreg[0];
         default:  txd_nxt = 1'b1;
      endcase
   end

endmodule

// File: rtl/pubkey_uart_streamer.sv
// Accepts one {pub_x, pub_y} key per handshake and streams it as lowercase hex
// over 8N1 UART. Define UART_CRLF_EN for a CR LF terminator (default: LF only).
module pubkey_uart_streamer
   import pubkey_uart_pkg::*;
#(
   parameter int BAUD_DIV = 104
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         pk_valid,
   output logic         pk_ready,
   input  logic [255:0] pub_x,
   input  logic [255:0] pub_y,
   output logic         txd,
   output logic         busy,
   output logic         msg_done
);

   msg_state_e   state, state_nxt;
   logic [511:0] hold;
   logic [7:0]   char_idx, next_idx, tx_byte;
   logic         accept, last_char, tx_start, tx_ready;

   assign accept    = pk_valid && (state == MSG_IDLE);
   assign last_char = (char_idx == (MSG_LEN - 8'd1));
   assign next_idx  = char_idx + 8'd1;
   assign tx_start  = accept || ((state == MSG_SEND) && tx_ready && !last_char);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= MSG_IDLE;
         char_idx <= '0;
      end else begin
         state <= state_nxt;
         if (accept)        char_idx <= '0;
         else if (tx_start) char_idx <= next_idx;
      end
   end

   // top nibble of hold is always the character after the one on the wire
   always_ff @(posedge clk) begin
      if (accept)        hold <= {pub_x[251:0], pub_y, 4'h0};
      else if (tx_start) hold <= {hold[507:0], 4'h0};
   end

   // first character comes straight from the port so txd falls right after the handshake
   always_comb begin
      if (state == MSG_IDLE)      tx_byte = nibble_to_ascii(pub_x[255:252]);
      else if (next_idx < NIBBLES) tx_byte = nibble_to_ascii(hold[511:508]);
`ifdef UART_CRLF_EN
      else if (next_idx == NIBBLES) tx_byte = ASCII_CR;
`endif
      else                         tx_byte = ASCII_LF;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         MSG_IDLE: if (pk_valid)              state_nxt = MSG_SEND;
         MSG_SEND: if (tx_ready && last_char) state_nxt = MSG_DONE;
         MSG_DONE:                            state_nxt = MSG_IDLE;
         default:                             state_nxt = MSG_IDLE;
      endcase
   end

   always_comb begin
      pk_ready = (state == MSG_IDLE);
      busy     = (state != MSG_IDLE);
      msg_done = (state == MSG_DONE);
   end

   uart_tx_byte #(
      .BAUD_DIV (BAUD_DIV)
   ) u_tx (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (tx_start),
      .byte_in (tx_byte),
      .ready   (tx_ready),
      .txd     (txd)
   );

endmodule

// File: tb/tb_pubkey_uart_streamer.sv
// Directed bench for pubkey_uart_streamer at BAUD_DIV=4: decodes every UART frame
// cycle by cycle and compares against a hex model and a table of hand-computed chars.
module tb_pubkey_uart_streamer;

   localparam int B = 4;
`ifdef UART_CRLF_EN
   localparam int         MSG_LEN = 130;
   localparam logic [7:0] TERM0   = 8'h0D;
`else
   localparam int         MSG_LEN = 129;
   localparam logic [7:0] TERM0   = 8'h0A;
`endif

   localparam logic [255:0] XA = {4{64'h0123456789abcdef}};
   localparam logic [255:0] YA = {256{1'b1}};
   localparam logic [255:0] XB = {8{32'hdeadbeef}};
   localparam logic [255:0] YB = {8{32'h0badf00d}};
   localparam logic [255:0] XC = {4{64'h0f1e2d3c4b5a6978}};
   localparam logic [255:0] YC = 256'h5;

   typedef struct {
      int         msg;
      int         idx;
      logic [7:0] exp;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         pk_valid = 1'b0;
   logic [255:0] pub_x = '0;
   logic [255:0] pub_y = '0;
   logic         pk_ready, txd, busy, msg_done;

   int         checks = 0;
   int         failures = 0;
   int         done_cnt = 0;
   logic [7:0] rx  [0:129];
   logic [7:0] rx1 [0:129];
   logic [7:0] rxa [0:129];
   vec_t       vecs [17];

   pubkey_uart_streamer #(.BAUD_DIV(B)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pk_valid (pk_valid),
      .pk_ready (pk_ready),
      .pub_x    (pub_x),
      .pub_y    (pub_y),
      .txd      (txd),
      .busy     (busy),
      .msg_done (msg_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (msg_done === 1'b1) done_cnt <= done_cnt + 1;

   initial begin
      #(600000);
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic logic [7:0] exp_char(input logic [255:0] x, input logic [255:0] y, input int i);
      logic [511:0] k;
      string        hexs;
      k    = {x, y};
      hexs = "0123456789abcdef";
      if (i < 128) return hexs[k[511 - 4*i -: 4]];
      if (i == MSG_LEN - 1) return 8'h0A;
      return 8'h0D;
   endfunction

   // Call at a negedge; returns at the negedge of the first start-bit cycle.
   task automatic drive_key(input string tag, input logic [255:0] x, input logic [255:0] y);
      int n;
      pub_x = x;
      pub_y = y;
      pk_valid = 1'b1;
      n = 0;
      while (pk_ready !== 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      chk({tag, "_accept"}, pk_ready, 1);
      @(negedge clk);
   endtask

   // Call at the negedge of the first start-bit cycle; returns at the msg_done negedge.
   task automatic recv_msg(input string tag, input logic [255:0] x, input logic [255:0] y);
      int         frame_err, ctrl_err, char_err, first_bad;
      logic [9:0] bits;
      frame_err = 0;
      ctrl_err  = 0;
      char_err  = 0;
      first_bad = -1;
      bits      = '0;
      for (int c = 0; c < MSG_LEN; c++) begin
         for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < B; k++) begin
               if (k == 0) bits[b] = txd;
               else if (txd !== bits[b]) frame_err++;
               if (busy !== 1'b1 || pk_ready !== 1'b0 || msg_done !== 1'b0) ctrl_err++;
               @(negedge clk);
            end
         end
         if (bits[0] !== 1'b0 || bits[9] !== 1'b1) frame_err++;
         rx[c] = bits[8:1];
         if (rx[c] !== exp_char(x, y, c)) begin
            char_err++;
            if (first_bad < 0) first_bad = c;
         end
      end
      chk({tag, "_frame_errs"}, frame_err, 0);
      chk({tag, "_ctrl_errs"}, ctrl_err, 0);
      chk($sformatf("%s_char_errs(first_bad=%0d)", tag, first_bad), char_err, 0);
      chk({tag, "_msg_done"}, msg_done, 1);
      chk({tag, "_ready_in_done"}, pk_ready, 0);
   endtask

   // Counts idle-high cycles from the current negedge up to the next start bit.
   task automatic wait_start(output int gap);
      gap = 0;
      while (txd !== 1'b0 && gap < 50) begin
         gap++;
         @(negedge clk);
      end
   endtask

   initial begin
      int gap, d0, idle_err;
      logic [7:0] v;

      vecs[0]  = '{1, 0,   8'h30};
      vecs[1]  = '{1, 62,  8'h30};
      vecs[2]  = '{1, 63,  8'h31};
      vecs[3]  = '{1, 64,  8'h30};
      vecs[4]  = '{1, 126, 8'h30};
      vecs[5]  = '{1, 127, 8'h32};
      vecs[6]  = '{1, 128, TERM0};
      vecs[7]  = '{2, 0,   8'h30};
      vecs[8]  = '{2, 1,   8'h31};
      vecs[9]  = '{2, 9,   8'h39};
      vecs[10] = '{2, 10,  8'h61};
      vecs[11] = '{2, 15,  8'h66};
      vecs[12] = '{2, 16,  8'h30};
      vecs[13] = '{2, 63,  8'h66};
      vecs[14] = '{2, 64,  8'h66};
      vecs[15] = '{2, 127, 8'h66};
      vecs[16] = '{2, 128, TERM0};

      // reset held for 5 cycles
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("rst_txd", txd, 1);
      chk("rst_pk_ready", pk_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_msg_done", msg_done, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_txd", txd, 1);
      chk("idle_pk_ready", pk_ready, 1);

      // single key x=1, y=2
      drive_key("m1", 256'h1, 256'h2);
      pk_valid = 1'b0;
      recv_msg("m1", 256'h1, 256'h2);
      rx1 = rx;

      // three keys back to back; the next key sits on the bus while the current one is busy
      drive_key("a", XA, YA);
      d0 = done_cnt;
      pub_x = XB;
      pub_y = YB;
      recv_msg("a", XA, YA);
      rxa = rx;
      wait_start(gap);
      chk("gap_a_b", gap, 2);
      pub_x = XC;
      pub_y = YC;
      recv_msg("b", XB, YB);
      wait_start(gap);
      chk("gap_b_c", gap, 2);
      pk_valid = 1'b0;
      recv_msg("c", XC, YC);
      @(negedge clk);
      chk("c_ready_after_done", pk_ready, 1);
      chk("abc_done_pulses", done_cnt - d0, 3);

      // reset in the middle of character 50 (a data bit that is 0)
      drive_key("d", 256'h1, 256'h2);
      pk_valid = 1'b0;
      repeat (50*10*B + 13) @(negedge clk);
      chk("d_busy_midframe", busy, 1);
      chk("d_txd_midframe", txd, 0);
      d0 = done_cnt;
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_txd", txd, 1);
      chk("abort_pk_ready", pk_ready, 1);
      chk("abort_busy", busy, 0);
      chk("abort_msg_done", msg_done, 0);
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      idle_err = 0;
      repeat (60) begin
         if (txd !== 1'b1 || msg_done !== 1'b0 || pk_ready !== 1'b1) idle_err++;
         @(negedge clk);
      end
      chk("abort_idle_errs", idle_err, 0);
      chk("abort_no_done", done_cnt - d0, 0);

      // hand-computed character table
      for (int i = 0; i < 17; i++) begin
         v = (vecs[i].msg == 1) ? rx1[vecs[i].idx] : rxa[vecs[i].idx];
         chk($sformatf("vec%0d_m%0d_char%0d", i, vecs[i].msg, vecs[i].idx), v, vecs[i].exp);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
